// File: rtl/pbvi_backup_sched_if.sv
// Memory-side bus of the PBVI backup scheduler: read request/response and per-point result write.
interface pbvi_backup_sched_if #(
    parameter int unsigned N_POINTS = 16,
    parameter int unsigned W        = 16
);
    localparam int unsigned PW = $clog2(N_POINTS);

    logic            rd_valid;
    logic [PW-1:0]   rd_pt;
    logic [1:0]      rd_act;
    logic [2*W-1:0]  rd_belief;
    logic [2*W-1:0]  rd_gamma;
    logic            wr_en;
    logic [PW-1:0]   wr_pt;
    logic [1:0]      wr_action;
    logic [2*W-1:0]  wr_alpha;

    modport master (
        output rd_valid, rd_pt, rd_act,
        input  rd_belief, rd_gamma,
        output wr_en, wr_pt, wr_action, wr_alpha
    );

    modport slave (
        input  rd_valid, rd_pt, rd_act,
        output rd_belief, rd_gamma,
        input  wr_en, wr_pt, wr_action, wr_alpha
    );
endinterface

// File: rtl/pbvi_backup_sched.sv
// Time-multiplexed PBVI argmax backup: one dot product per (point, action) pair on a shared
// multiplier pair, running max per point, winning action/alpha written back once per point.
module pbvi_backup_sched #(
    parameter int unsigned N_POINTS  = 16,
    parameter int unsigned N_ACTIONS = 3,
    parameter int unsigned W         = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stall,
    pbvi_backup_sched_if.master bus,
    output logic                busy,
    output logic                en_loop
);
    localparam int unsigned PW = $clog2(N_POINTS);
    localparam logic [PW-1:0] LAST_PT  = PW'(N_POINTS - 1);
    localparam logic [1:0]    LAST_ACT = 2'(N_ACTIONS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   pt_q, pt_d;
    logic [1:0]      act_q, act_d;
    logic            s1_valid_q, s1_valid_d;
    logic [PW-1:0]   s1_pt_q, s1_pt_d;
    logic [1:0]      s1_act_q, s1_act_d;
    logic [W-1:0]    max_q, max_d;
    logic [1:0]      best_q, best_d;
    logic [2*W-1:0]  alpha_q, alpha_d;
    logic            wr_en_q, wr_en_d;
    logic [PW-1:0]   wr_pt_q, wr_pt_d;
    logic [1:0]      wr_action_q, wr_action_d;
    logic [2*W-1:0]  wr_alpha_q, wr_alpha_d;

    logic            issue;
    logic            last_pair;
    logic [W-1:0]    prod0, prod1, val;
    logic            take;

    // State register plus all pipeline/counter registers; stall freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pt_q        <= '0;
            act_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_pt_q     <= '0;
            s1_act_q    <= '0;
            max_q       <= '0;
            best_q      <= '0;
            alpha_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_pt_q     <= '0;
            wr_action_q <= '0;
            wr_alpha_q  <= '0;
        end else if (!stall) begin
            state_q     <= state_d;
            pt_q        <= pt_d;
            act_q       <= act_d;
            s1_valid_q  <= s1_valid_d;
            s1_pt_q     <= s1_pt_d;
            s1_act_q    <= s1_act_d;
            max_q       <= max_d;
            best_q      <= best_d;
            alpha_q     <= alpha_d;
            wr_en_q     <= wr_en_d;
            wr_pt_q     <= wr_pt_d;
            wr_action_q <= wr_action_d;
            wr_alpha_q  <= wr_alpha_d;
        end
    end

    assign last_pair = (act_q == LAST_ACT) && (pt_q == LAST_PT);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_pair) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign issue = (state_q == RUN);

    // Products and sum are all taken modulo 2^W.
    assign prod0 = W'(bus.rd_belief[W-1:0]   * bus.rd_gamma[W-1:0]);
    assign prod1 = W'(bus.rd_belief[2*W-1:W] * bus.rd_gamma[2*W-1:W]);
    assign val   = W'(prod0 + prod1);
    assign take  = (s1_act_q == 2'd0) || (val > max_q);

    // Request counters (action inner, point outer), stage-1 max tracking and stage-2 write.
    always_comb begin
        pt_d        = pt_q;
        act_d       = act_q;
        s1_valid_d  = issue;
        s1_pt_d     = pt_q;
        s1_act_d    = act_q;
        max_d       = max_q;
        best_d      = best_q;
        alpha_d     = alpha_q;
        wr_en_d     = 1'b0;
        wr_pt_d     = wr_pt_q;
        wr_action_d = wr_action_q;
        wr_alpha_d  = wr_alpha_q;

        if (issue) begin
            if (act_q == LAST_ACT) begin
                act_d = 2'd0;
                pt_d  = (pt_q == LAST_PT) ? '0 : PW'(pt_q + PW'(1));
            end else begin
                act_d = 2'(act_q + 2'd1);
            end
        end

        if (s1_valid_q && take) begin
            max_d   = val;
            best_d  = s1_act_q;
            alpha_d = bus.rd_gamma;
        end

        if (s1_valid_q && (s1_act_q == LAST_ACT)) begin
            wr_en_d     = 1'b1;
            wr_pt_d     = s1_pt_q;
            wr_action_d = best_d;
            wr_alpha_d  = alpha_d;
        end
    end

    // Output decode; strobes are masked while stalled so they re-assert afterwards.
    always_comb begin
        bus.rd_valid  = issue && !stall;
        bus.rd_pt     = pt_q;
        bus.rd_act    = act_q;
        bus.wr_en     = wr_en_q && !stall;
        bus.wr_pt     = wr_pt_q;
        bus.wr_action = wr_action_q;
        bus.wr_alpha  = wr_alpha_q;
        busy          = (state_q != IDLE);
        en_loop       = (state_q == DONE) && !stall;
    end
endmodule

// File: tb/tb_pbvi_backup_sched.sv
// Directed table-driven bench for pbvi_backup_sched with a behavioural belief/gamma memory.
module tb_pbvi_backup_sched;
    localparam int unsigned NP = 16;
    localparam int unsigned W  = 16;

    typedef struct packed {
        logic [31:0]      bel;
        logic [2:0][31:0] gam;
        logic [1:0]       exp_act;
        logic [31:0]      exp_alpha;
    } vec_t;

    typedef struct packed {
        logic [3:0]  pt;
        logic [1:0]  act;
        logic [31:0] alpha;
        int          cyc;
    } wr_rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic stall = 1'b0;
    logic busy, en_loop;

    pbvi_backup_sched_if #(.N_POINTS(NP), .W(W)) bus ();

    pbvi_backup_sched #(.N_POINTS(NP), .N_ACTIONS(3), .W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .bus(bus), .busy(busy), .en_loop(en_loop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base = 0;

    vec_t tbl_a [NP];
    vec_t tbl_b [NP];
    vec_t exp_tbl [NP];
    logic [31:0] mem_b [NP];
    logic [31:0] mem_g [NP][3];
    wr_rec_t wr_q [$];
    int el_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory answers one cycle after an unstalled request and holds otherwise.
    always @(posedge clk) begin
        if (bus.rd_valid) begin
            bus.rd_belief <= mem_b[bus.rd_pt];
            bus.rd_gamma  <= mem_g[bus.rd_pt][bus.rd_act];
        end
    end

    always @(negedge clk) begin
        if (bus.wr_en) wr_q.push_back('{pt: bus.wr_pt, act: bus.wr_action, alpha: bus.wr_alpha, cyc: cyc});
        if (en_loop) el_q.push_back(cyc);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [15:0] b0, b1, g00, g01, g10, g11, g20, g21,
                                input logic [1:0] a, input logic [31:0] al);
        vec_t v;
        v.bel       = {b1, b0};
        v.gam       = {{g21, g20}, {g11, g10}, {g01, g00}};
        v.exp_act   = a;
        v.exp_alpha = al;
        return v;
    endfunction

    task automatic load(input vec_t t [NP]);
        for (int i = 0; i < NP; i++) begin
            exp_tbl[i] = t[i];
            mem_b[i]   = t[i].bel;
            for (int a = 0; a < 3; a++) mem_g[i][a] = t[i].gam[a];
        end
    endtask

    task automatic run_pass(input string tag, input bit do_start,
                            input int s1_lo, input int s1_hi, input int s2_lo, input int s2_hi,
                            input int ign_k, input int restart_k, input int exp_el);
        int k0;
        wr_q.delete();
        el_q.delete();
        k0   = do_start ? 0 : 1;
        base = cyc - k0;
        for (int k = k0; k <= exp_el + 3; k++) begin
            start = (do_start && k == 0) || (k == ign_k) || (k == restart_k);
            stall = (k >= s1_lo && k <= s1_hi) || (k >= s2_lo && k <= s2_hi);
            tick();
            if (k == restart_k) break;
        end
        start = 1'b0;
        stall = 1'b0;
        chk({tag, " nwrites"}, 64'(wr_q.size()), 64'd16);
        for (int i = 0; i < wr_q.size() && i < NP; i++) begin
            chk($sformatf("%s wr_pt[%0d]", tag, i), 64'(wr_q[i].pt), 64'(i));
            chk($sformatf("%s wr_action[%0d]", tag, i), 64'(wr_q[i].act), 64'(exp_tbl[i].exp_act));
            chk($sformatf("%s wr_alpha[%0d]", tag, i), 64'(wr_q[i].alpha), 64'(exp_tbl[i].exp_alpha));
        end
        chk({tag, " n_en_loop"}, 64'(el_q.size()), 64'd1);
        if (el_q.size() > 0) chk({tag, " en_loop_cycle"}, 64'(el_q[0] - base), 64'(exp_el));
        if (wr_q.size() > 0) chk({tag, " last_wr_cycle"}, 64'(wr_q[wr_q.size()-1].cyc - base), 64'(exp_el));
    endtask

    initial begin
        // All gammas (1,0), belief (p,0): every action ties, action 0 wins.
        for (int i = 0; i < NP; i++)
            tbl_a[i] = mk(16'(i), 16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 2'd0, 32'h0000_0001);

        tbl_b[0]  = mk(16'd1, 16'd1, 16'd1, 16'd1, 16'd2, 16'd0, 16'd0, 16'd2, 2'd0, 32'h0001_0001);
        tbl_b[1]  = mk(16'd1, 16'd0, 16'd1, 16'd9, 16'd5, 16'd0, 16'd3, 16'd0, 2'd1, 32'h0000_0005);
        tbl_b[2]  = mk(16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd2, 16'd0, 16'd3, 2'd2, 32'h0003_0000);
        tbl_b[3]  = mk(16'd2, 16'd2, 16'd5, 16'd5, 16'd1, 16'd1, 16'd2, 16'd2, 2'd0, 32'h0005_0005);
        tbl_b[4]  = mk(16'd3, 16'd1, 16'd1, 16'd1, 16'd0, 16'd4, 16'd1, 16'd2, 2'd2, 32'h0002_0001);
        tbl_b[5]  = mk(16'd2, 16'd3, 16'd4, 16'd1, 16'd1, 16'd4, 16'd3, 16'd3, 2'd2, 32'h0003_0003);
        tbl_b[6]  = mk(16'hFFFF, 16'd0, 16'd2, 16'd0, 16'd3, 16'd0, 16'd0, 16'd0, 2'd0, 32'h0000_0002);
        tbl_b[7]  = mk(16'h8000, 16'h8000, 16'd1, 16'd1, 16'd0, 16'd0, 16'd1, 16'd0, 2'd2, 32'h0000_0001);
        tbl_b[8]  = mk(16'h0100, 16'h0100, 16'h0100, 16'd0, 16'd1, 16'd0, 16'd0, 16'd2, 2'd2, 32'h0002_0000);
        tbl_b[9]  = mk(16'd10, 16'd0, 16'd1, 16'd0, 16'd2, 16'd0, 16'd2, 16'd0, 2'd1, 32'h0000_0002);
        tbl_b[10] = mk(16'd1, 16'd2, 16'd100, 16'd0, 16'd0, 16'd50, 16'd0, 16'd49, 2'd0, 32'h0000_0064);
        tbl_b[11] = mk(16'd0, 16'd0, 16'd7, 16'd8, 16'd9, 16'd9, 16'd1, 16'd1, 2'd0, 32'h0008_0007);
        tbl_b[12] = mk(16'hFFFF, 16'hFFFF, 16'd1, 16'd1, 16'hFFFF, 16'd0, 16'd1, 16'd0, 2'd2, 32'h0000_0001);
        tbl_b[13] = mk(16'd4, 16'd4, 16'd0, 16'd0, 16'h4000, 16'd0, 16'h3FFF, 16'd0, 2'd2, 32'h0000_3FFF);
        tbl_b[14] = mk(16'd1, 16'd1, 16'd0, 16'd0, 16'd3, 16'd4, 16'd2, 16'd4, 2'd1, 32'h0004_0003);
        tbl_b[15] = mk(16'd2, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd1, 16'd0, 2'd0, 32'h0001_0001);

        rst = 1'b1;
        repeat (3) tick();
        chk("reset outputs",
            {bus.rd_valid, bus.wr_en, busy, en_loop, 4'(bus.rd_pt), bus.rd_act,
             4'(bus.wr_pt), bus.wr_action, bus.wr_alpha},
            '0);
        rst = 1'b0;
        tick();

        load(tbl_a);
        run_pass("ties", 1'b1, -1, -2, -1, -2, -1, -1, 50);

        load(tbl_b);
        run_pass("vectors", 1'b1, -1, -2, -1, -2, -1, -1, 50);

        run_pass("stalled", 1'b1, 10, 14, 55, 59, -1, -1, 60);

        // Mid-run start ignored; start right after en_loop launches the next pass at once.
        run_pass("ign_start", 1'b1, -1, -2, -1, -2, 20, 51, 50);
        chk("restart rd_valid", 64'(bus.rd_valid), 64'd1);
        chk("restart rd_pt", 64'(bus.rd_pt), 64'd0);
        chk("restart rd_act", 64'(bus.rd_act), 64'd0);
        chk("restart busy", 64'(busy), 64'd1);
        run_pass("chained", 1'b0, -1, -2, -1, -2, -1, -1, 50);

        // Reset in cycle 30 of a pass.
        wr_q.delete();
        el_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (29) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst outputs",
            {bus.rd_valid, bus.wr_en, busy, en_loop, 4'(bus.rd_pt), bus.rd_act,
             4'(bus.wr_pt), bus.wr_action, bus.wr_alpha},
            '0);
        repeat (60) tick();
        chk("rst nwrites_before", 64'(wr_q.size()), 64'd9);
        chk("rst n_en_loop", 64'(el_q.size()), 64'd0);
        run_pass("after_rst", 1'b1, -1, -2, -1, -2, -1, -1, 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
